// File: rtl/pipe_scheduler.sv
// pipe_scheduler
//   Per-frame controller for the pipe line-drawer datapath. Keeps a table of
//   pipe positions and scrolls it left on each frame tick. A pipe that reaches
//   the left margin is respawned at the far right with a new gap height. The
//   controller then walks the single pipe_drawer through every visible pipe,
//   one pipe at a time, using an enable/done handshake.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   frame_tick  one-cycle pulse requesting a frame update
//   run         1 = scroll pipes this frame, 0 = freeze positions (still draw)
//   gap_y       random gap height, sampled when a pipe respawns
//   drw_enable  registered enable to pipe_drawer
//   drw_pipe_x  pipe x to drawer, stable while drw_enable=1
//   drw_pipe_y  pipe y to drawer, stable while drw_enable=1
//   drw_done    done pulse from pipe_drawer
//   busy        high whenever the controller is not idle
//   frame_done  one-cycle pulse once every pipe has been processed
//   spawn       high in the cycle gap_y is consumed
//   score       one-cycle pulse per pipe crossing BIRD_X
//   overrun     one-cycle pulse when frame_tick arrives while busy
module pipe_scheduler #(
  parameter int NUM_PIPES = 3,
  parameter int SPACING   = 220,
  parameter int INIT_X    = 400,
  parameter int SPEED     = 2,
  parameter int MIN_X     = 31,
  parameter int SCREEN_W  = 640,
  parameter int BIRD_X    = 250,
  parameter int GAP_MIN   = 150,
  parameter int GAP_MAX   = 420,
  parameter int INIT_Y    = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        run,
  input  logic [10:0] gap_y,
  output logic        drw_enable,
  output logic [10:0] drw_pipe_x,
  output logic [10:0] drw_pipe_y,
  input  logic        drw_done,
  output logic        busy,
  output logic        frame_done,
  output logic        spawn,
  output logic        score,
  output logic        overrun
);

  localparam logic [10:0] SPEED_W     = 11'(SPEED);
  localparam logic [10:0] RESPAWN_LIM = 11'(MIN_X + SPEED);
  localparam logic [10:0] WRAP_W      = 11'(NUM_PIPES * SPACING);
  localparam logic [10:0] VIS_MAX     = 11'(SCREEN_W + 30);
  localparam logic [10:0] BIRD_W      = 11'(BIRD_X);
  localparam logic [10:0] GAP_MIN_W   = 11'(GAP_MIN);
  localparam logic [10:0] GAP_MAX_W   = 11'(GAP_MAX);
  localparam logic [10:0] INIT_Y_W    = 11'(INIT_Y);
  localparam logic [2:0]  LAST_IDX    = 3'(NUM_PIPES - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SEL,
    DRAW,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  idx;

  // The table is sized for the full 3-bit slot counter so that indexing by
  // idx is always in range; slots at or beyond NUM_PIPES are never visited.
  logic [10:0] pipe_x [8];
  logic [10:0] pipe_y [8];

  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic [10:0] moved_x;
  logic [10:0] new_x;
  logic [10:0] clamped_gap;
  logic        is_respawn;
  logic        crosses;
  logic        visible;
  logic        last;

  // Per-slot arithmetic shared by the MOVE and SEL states. A respawning pipe
  // never scores, even though its pre-wrap position would be below BIRD_X.
  always_comb begin
    cur_x       = pipe_x[idx];
    cur_y       = pipe_y[idx];
    moved_x     = cur_x - SPEED_W;
    is_respawn  = run && (cur_x < RESPAWN_LIM);
    new_x       = cur_x;
    if (is_respawn) begin
      new_x = moved_x + WRAP_W;
    end else if (run) begin
      new_x = moved_x;
    end
    clamped_gap = gap_y;
    if (gap_y < GAP_MIN_W) begin
      clamped_gap = GAP_MIN_W;
    end else if (gap_y > GAP_MAX_W) begin
      clamped_gap = GAP_MAX_W;
    end
    crosses     = run && !is_respawn && (cur_x > BIRD_W) && (moved_x <= BIRD_W);
    visible     = (cur_x <= VIS_MAX);
    last        = (idx == LAST_IDX);
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign spawn      = (state == MOVE) && is_respawn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (frame_tick) next_state = MOVE;
      MOVE: if (last) next_state = SEL;
      SEL: begin
        if (visible) begin
          next_state = DRAW;
        end else if (last) begin
          next_state = DONE;
        end
      end
      DRAW: begin
        if (drw_done) begin
          next_state = last ? DONE : SEL;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Slot counter, pipe table, drawer handshake and the registered pulses.
  // drw_enable is cleared on the same edge that samples drw_done so that the
  // drawer's first idle cycle already sees enable low and does not restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= 3'd0;
      drw_enable <= 1'b0;
      drw_pipe_x <= 11'd0;
      drw_pipe_y <= 11'd0;
      score      <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        pipe_x[i] <= 11'(INIT_X + i * SPACING);
        pipe_y[i] <= INIT_Y_W;
      end
    end else begin
      score   <= 1'b0;
      overrun <= frame_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_tick) idx <= 3'd0;
        end
        MOVE: begin
          pipe_x[idx] <= new_x;
          if (is_respawn) pipe_y[idx] <= clamped_gap;
          score <= crosses;
          idx   <= last ? 3'd0 : idx + 3'd1;
        end
        SEL: begin
          if (visible) begin
            drw_pipe_x <= cur_x;
            drw_pipe_y <= cur_y;
            drw_enable <= 1'b1;
          end else if (!last) begin
            idx <= idx + 3'd1;
          end
        end
        DRAW: begin
          if (drw_done) begin
            drw_enable <= 1'b0;
            if (!last) idx <= idx + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler
//   Self-checking bench for pipe_scheduler. A frame-level reference model of
//   the pipe table predicts, for every frame, which pipes get drawn and with
//   which coordinates, plus the spawn, score, overrun and frame_done counts.
module tb_pipe_scheduler;

  localparam int NUM_PIPES = 3;
  localparam int SPACING   = 220;
  localparam int INIT_X    = 400;
  localparam int SPEED     = 2;
  localparam int MIN_X     = 31;
  localparam int SCREEN_W  = 640;
  localparam int BIRD_X    = 250;
  localparam int GAP_MIN   = 150;
  localparam int GAP_MAX   = 420;
  localparam int INIT_Y    = 300;
  localparam int FRAME_BOUND = 5000;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        run;
  logic [10:0] gap_y;
  logic        drw_enable;
  logic [10:0] drw_pipe_x;
  logic [10:0] drw_pipe_y;
  logic        drw_done;
  logic        busy;
  logic        frame_done;
  logic        spawn;
  logic        score;
  logic        overrun;

  pipe_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .gap_y      (gap_y),
    .drw_enable (drw_enable),
    .drw_pipe_x (drw_pipe_x),
    .drw_pipe_y (drw_pipe_y),
    .drw_done   (drw_done),
    .busy       (busy),
    .frame_done (frame_done),
    .spawn      (spawn),
    .score      (score),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Reference model of the pipe table.
  int mx [NUM_PIPES];
  int my [NUM_PIPES];

  // Observations gathered per frame.
  int obsDx [$];
  int obsDy [$];
  int obsDone;
  int obsSpawn;
  int obsScore;
  int obsOverrun;
  int drawLatency;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic resetModel();
    for (int i = 0; i < NUM_PIPES; i++) begin
      mx[i] = INIT_X + i * SPACING;
      my[i] = INIT_Y;
    end
  endtask

  // Pulse counters sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) obsDone++;
      if (spawn)      obsSpawn++;
      if (score)      obsScore++;
      if (overrun)    obsOverrun++;
    end
  end

  // Drawer model: records each enable, answers with done after drawLatency
  // cycles and confirms enable is low on the cycle following done.
  initial begin
    bit active = 0;
    int waitCnt = 0;
    int capX = 0;
    int capY = 0;
    drw_done = 1'b0;
    forever begin
      @(negedge clk);
      if (drw_done) begin
        drw_done = 1'b0;
        active = 0;
        checkOutput("enable_after_done", 32'(drw_enable), 32'd0);
      end else if (active) begin
        if (!drw_enable) begin
          active = 0;
        end else if (waitCnt == 0) begin
          checkOutput("x_stable", 32'(drw_pipe_x), 32'(capX));
          checkOutput("y_stable", 32'(drw_pipe_y), 32'(capY));
          drw_done = 1'b1;
        end else begin
          waitCnt--;
        end
      end else if (drw_enable && reset) begin
        active = 1;
        waitCnt = drawLatency;
        capX = int'(drw_pipe_x);
        capY = int'(drw_pipe_y);
        obsDx.push_back(capX);
        obsDy.push_back(capY);
      end
    end
  end

  // Runs one frame and compares it against the model. extraTick >= 1 issues
  // a second frame_tick that many cycles into the frame (always while busy).
  task automatic applyStimulus(input bit runVal, input int gap, input int latency, input int extraTick);
    int expDx [$];
    int expDy [$];
    int expSpawn = 0;
    int expScore = 0;
    int cnt = 0;
    int g;
    int old;
    int n;

    g = (gap < GAP_MIN) ? GAP_MIN : ((gap > GAP_MAX) ? GAP_MAX : gap);
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (runVal) begin
        old = mx[i];
        if (old < MIN_X + SPEED) begin
          mx[i] = old - SPEED + NUM_PIPES * SPACING;
          my[i] = g;
          expSpawn++;
        end else begin
          mx[i] = old - SPEED;
          if (old > BIRD_X && mx[i] <= BIRD_X) expScore++;
        end
      end
    end
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (mx[i] <= SCREEN_W + 30) begin
        expDx.push_back(mx[i]);
        expDy.push_back(my[i]);
      end
    end

    obsDx.delete();
    obsDy.delete();
    obsDone = 0;
    obsSpawn = 0;
    obsScore = 0;
    obsOverrun = 0;
    drawLatency = latency;
    run = runVal;
    gap_y = 11'(gap);

    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    if (extraTick > 0) begin
      repeat (extraTick - 1) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    while (busy && cnt < FRAME_BOUND) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("frame_timeout_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("no_queued_frame", 32'(busy), 32'd0);

    checkOutput("frame_done_count", 32'(obsDone), 32'd1);
    checkOutput("spawn_count", 32'(obsSpawn), 32'(expSpawn));
    checkOutput("score_count", 32'(obsScore), 32'(expScore));
    checkOutput("overrun_count", 32'(obsOverrun), (extraTick > 0) ? 32'd1 : 32'd0);
    checkOutput("draw_count", 32'(obsDx.size()), 32'(expDx.size()));
    n = (obsDx.size() < expDx.size()) ? obsDx.size() : expDx.size();
    for (int i = 0; i < n; i++) begin
      checkOutput("draw_x", 32'(obsDx[i]), 32'(expDx[i]));
      checkOutput("draw_y", 32'(obsDy[i]), 32'(expDy[i]));
    end
  endtask

  initial begin
    int cnt;
    int gsel;
    int gap;
    reset = 1'b0;
    frame_tick = 1'b0;
    run = 1'b0;
    gap_y = 11'd0;
    drawLatency = 0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_enable", 32'(drw_enable), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_spawn", 32'(spawn), 32'd0);
    checkOutput("reset_score", 32'(score), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_pipe_x", 32'(drw_pipe_x), 32'd0);
    checkOutput("reset_pipe_y", 32'(drw_pipe_y), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] first frame, drawer latency 20");
    applyStimulus(1'b1, 300, 20, 0);
    $display("[TB] frozen frame");
    applyStimulus(1'b0, 300, 3, 0);
    $display("[TB] overrun frame");
    applyStimulus(1'b1, 300, 5, 3);

    $display("[TB] randomized frames through respawns and score crossings");
    for (int f = 0; f < 450; f++) begin
      gsel = $urandom_range(0, 4);
      case (gsel)
        0:       gap = 100;
        1:       gap = 500;
        2:       gap = 150;
        3:       gap = 420;
        default: gap = $urandom_range(0, 2047);
      endcase
      applyStimulus(($urandom_range(0, 9) != 0), gap, $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("[TB] reset in the middle of a draw");
    drawLatency = 30;
    run = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    cnt = 0;
    while (!drw_enable && cnt < FRAME_BOUND) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("mid_draw_enable_seen", 32'(drw_enable), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_reset_enable", 32'(drw_enable), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_pipe_x", 32'(drw_pipe_x), 32'd0);
    resetModel();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 200, 2, 0);
    applyStimulus(1'b1, 200, 1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
- Per-frame controller for the pipe line-drawer datapath.
- Holds a table of NUM_PIPES pipe positions and scrolls them left once per frame tick.
- Respawns each pipe that reaches the left margin, using an externally supplied random gap height.
- Then sequences the single pipe_drawer through every visible pipe, one at a time, with an enable/done handshake. It signals frame completion and score events to the game FSM.

Parameters:
NUM_PIPES, 3, number of pipe slots (1..8)
SPACING, 220, horizontal distance between consecutive pipes (pixels)
INIT_X, 400, reset x of pipe 0; pipe i resets to INIT_X + i*SPACING
SPEED, 2, pixels moved left per frame when run=1
MIN_X, 31, smallest legal pipe_x (keeps drawer pipe_x-30 >= 1)
SCREEN_W, 640, visible width; pipe is drawn only if pipe_x <= SCREEN_W+30
BIRD_X, 250, x column used for score detection
GAP_MIN, 150, lower clamp for respawn pipe_y
GAP_MAX, 420, upper clamp for respawn pipe_y
INIT_Y, 300, reset pipe_y of all slots

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse requesting a frame update
run  in  1  1 = scroll pipes this frame; 0 = freeze positions, still draw
gap_y  in  11  random gap height, sampled on respawn
drw_enable  out  1  enable to pipe_drawer (registered)
drw_pipe_x  out  11  pipe_x to drawer, stable while drw_enable=1
drw_pipe_y  out  11  pipe_y to drawer, stable while drw_enable=1
drw_done  in  1  drawer done pulse
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse when all pipes processed
spawn  out  1  high in the cycle gap_y is consumed
score  out  1  one-cycle pulse per pipe crossing BIRD_X
overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, idx=0.
  - Outputs drw_enable, frame_done, score, overrun, spawn = 0; drw_pipe_x/y = 0.
  - Table: x[i] = INIT_X + i*SPACING, y[i] = INIT_Y.
  - Takes effect immediately mid-operation: drw_enable drops without waiting for drw_done.
- States: IDLE, MOVE, SEL, DRAW, DONE. idx is a 3-bit slot counter.
- IDLE:
  - frame_tick=1 -> MOVE, idx=0.
  - Otherwise hold.
- MOVE (one cycle per slot; exactly NUM_PIPES cycles):
  - If run=1 and x[idx] < MIN_X+SPEED:
    - Respawn: x[idx] <= x[idx] - SPEED + NUM_PIPES*SPACING; y[idx] <= clamp(gap_y, GAP_MIN, GAP_MAX).
    - spawn=1 this cycle (combinational).
  - Else if run=1: x[idx] <= x[idx] - SPEED.
  - run=0: no change, spawn=0.
  - score pulses next cycle iff old x > BIRD_X and new x <= BIRD_X. A respawned pipe never scores.
  - idx==NUM_PIPES-1 -> SEL with idx=0; else idx++.
- SEL:
  - If x[idx] <= SCREEN_W+30: drw_pipe_x <= x[idx], drw_pipe_y <= y[idx], drw_enable <= 1 -> DRAW.
  - Else skip: if idx is last -> DONE, else idx++ and stay in SEL (one cycle per skipped slot).
- DRAW:
  - Hold drw_enable=1 and the coordinates until drw_done=1 is sampled.
  - On that edge drw_enable <= 0, so the drawer's first IDLE cycle sees enable=0 and does not restart.
  - Then last idx -> DONE, else idx++ -> SEL.
  - No timeout.
- DONE: frame_done=1 for one cycle -> IDLE.
- busy = (state != IDLE).
- frame_tick while busy: ignored, overrun=1 next cycle. No queueing.
- Arithmetic is 11-bit unsigned. Respawn x must fit 11 bits: with defaults, max respawn x = 32-2+660 = 690.
- drw_done while not in DRAW: ignored.
- Minimum frame latency with no visible pipes: 1 (IDLE) + NUM_PIPES (MOVE) + NUM_PIPES (SEL) + 1 (DONE) cycles.

Test Plan:
1. Reset then tick, run=1, drawer model returning done 20 cycles after enable → expected:
   - Table becomes x = 398, 618, 838.
   - drw_enable for pipe0 (398,300), then pipe1 (618,300); pipe2 skipped (838 > 670).
   - Exactly one frame_done; enable low on the cycle after each done.
2. Force x[0]=32, gap_y=100, tick → x[0]=690, y[0]=150 (clamped), spawn high one cycle. gap_y=500 → y[0]=420.
3. x[1]=252, tick → x[1]=250, single score pulse. Next frame (250→248) → no score.
4. run=0, tick → positions unchanged, all visible pipes still drawn, no spawn/score.
5. frame_tick during DRAW → overrun one cycle, frame proceeds unaffected, single frame_done.
6. reset asserted mid-DRAW → drw_enable=0 and busy=0 immediately; table returns to 400/620/840.
